// File: rtl/gpio_debounce_if.sv
// Pad-side and controller-side signal bundle of the GPIO input conditioner.
// The host drives pads and configuration; the conditioner returns clean levels.
interface gpio_debounce_if #(
    parameter int PIN_NUM   = 32,
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16
);
    logic [PIN_NUM-1:0]   gpio_pad_i;
    logic [PIN_NUM-1:0]   en_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic [CNT_WIDTH-1:0] thresh_i;
    logic [PIN_NUM-1:0]   gpio_in_o;
    logic [PIN_NUM-1:0]   chg_o;

    modport master (
        output gpio_pad_i,
        output en_i,
        output div_i,
        output thresh_i,
        input  gpio_in_o,
        input  chg_o
    );

    modport slave (
        input  gpio_pad_i,
        input  en_i,
        input  div_i,
        input  thresh_i,
        output gpio_in_o,
        output chg_o
    );
endinterface

// File: rtl/gpio_debounce.sv
// Per-pin GPIO input conditioner: 2-flop synchroniser, shared sample
// prescaler and per-pin stability counter with bypass and change pulse.
module gpio_debounce #(
    parameter int PIN_NUM   = 32,
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16
) (
    input logic clk_i,
    input logic rst_n_i,
    gpio_debounce_if.slave bus
);
    localparam int CW1 = CNT_WIDTH + 1;

    logic [PIN_NUM-1:0]   sync_d1;
    logic [PIN_NUM-1:0]   sync_q;
    logic [PIN_NUM-1:0]   out_q;
    logic [PIN_NUM-1:0]   out_d;
    logic [PIN_NUM-1:0]   chg_q;
    logic [DIV_WIDTH-1:0] psc_cnt;
    logic                 tick;
    logic [CW1-1:0]       thr;
    logic [CNT_WIDTH-1:0] cnt   [PIN_NUM];
    logic [CNT_WIDTH-1:0] cnt_d [PIN_NUM];

    // >= rather than == so lowering div_i never forces a full wrap-around
    assign tick = (psc_cnt >= bus.div_i);
    assign thr  = (bus.thresh_i == '0) ? CW1'(1) : {1'b0, bus.thresh_i};

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < PIN_NUM; i++) begin
            cnt_d[i] = cnt[i];
            if (!bus.en_i[i]) begin
                out_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else if (tick) begin
                if (sync_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if ({1'b0, cnt[i]} + CW1'(1) >= thr) begin
                    out_d[i] = sync_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_d1 <= '0;
            sync_q  <= '0;
            out_q   <= '0;
            chg_q   <= '0;
            psc_cnt <= '0;
            for (int i = 0; i < PIN_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_d1 <= bus.gpio_pad_i;
            sync_q  <= sync_d1;
            out_q   <= out_d;
            chg_q   <= out_d ^ out_q;
            psc_cnt <= tick ? '0 : psc_cnt + DIV_WIDTH'(1);
            for (int i = 0; i < PIN_NUM; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

    assign bus.gpio_in_o = out_q;
    assign bus.chg_o     = chg_q;
endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: stimulus pushes expected change
// events, a negedge monitor pops and compares them against chg_o pulses.
module tb_gpio_debounce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] chg;
        logic [31:0] lvl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_lvl = '0;

    gpio_debounce_if #(.PIN_NUM(32), .CNT_WIDTH(8), .DIV_WIDTH(16)) bus ();

    gpio_debounce #(.PIN_NUM(32), .CNT_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic push(input int at, input logic [31:0] m);
        exp_t e;
        exp_lvl = exp_lvl ^ m;
        e.cyc = at;
        e.chg = m;
        e.lvl = exp_lvl;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every chg_o pulse must match the oldest expected event
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missed_chg", 32'(cyc), 32'(e.cyc));
            end
            if (bus.chg_o != '0) begin
                if (q.size() == 0) begin
                    check("unexpected_chg", bus.chg_o, 32'h0);
                end else begin
                    e = q.pop_front();
                    check("chg_cycle", 32'(cyc), 32'(e.cyc));
                    check("chg_mask", bus.chg_o, e.chg);
                    check("chg_level", bus.gpio_in_o, e.lvl);
                end
            end
        end
    end

    initial begin
        int p;
        int r;
        bus.gpio_pad_i = '0;
        bus.en_i       = '1;
        bus.div_i      = '0;
        bus.thresh_i   = 8'd4;
        step(3);
        check("reset_out", bus.gpio_in_o, 32'h0);
        check("reset_chg", bus.chg_o, 32'h0);
        rst_n = 1'b1;
        step(20);
        check("idle_out", bus.gpio_in_o, 32'h0);
        check("idle_chg", bus.chg_o, 32'h0);

        // Filtered step on pin 3, div=0 thresh=4: 2 sync + 4 ticks
        bus.gpio_pad_i[3] = 1'b1;
        push(cyc + 6, 32'h8);
        step(10);
        bus.gpio_pad_i[3] = 1'b0;
        push(cyc + 6, 32'h8);
        step(10);

        // Glitch of 3 cycles is rejected and the count collapses
        bus.gpio_pad_i[0] = 1'b1;
        step(3);
        bus.gpio_pad_i[0] = 1'b0;
        step(1);
        check("glitch_cnt_mid", 32'(dut.cnt[0]), 32'd2);
        step(4);
        check("glitch_cnt_clr", 32'(dut.cnt[0]), 32'd0);
        check("glitch_out", bus.gpio_in_o, 32'h0);

        // 4-cycle pulse is accepted, then falls 4 ticks after release
        bus.gpio_pad_i[0] = 1'b1;
        push(cyc + 6, 32'h1);
        step(4);
        bus.gpio_pad_i[0] = 1'b0;
        push(cyc + 6, 32'h1);
        step(12);

        // Prescaler div=9 thresh=3: ticks 10 cycles apart from the set
        p = cyc;
        bus.div_i          = 16'd9;
        bus.thresh_i       = 8'd3;
        bus.gpio_pad_i[5]  = 1'b1;
        push(p + 30, 32'h20);
        step(31);
        bus.gpio_pad_i[5] = 1'b0;
        step(6);
        check("psc_before_lower", 32'(dut.psc_cnt), 32'd7);
        bus.div_i = 16'd2;
        push(p + 44, 32'h20);
        step(1);
        check("psc_after_lower", 32'(dut.psc_cnt), 32'd0);
        step(10);
        bus.div_i    = '0;
        bus.thresh_i = 8'd4;
        step(2);

        // Bypass on pin 7: every toggle appears 3 edges later
        bus.en_i[7] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.gpio_pad_i[7] = (j % 2 == 0);
            push(cyc + 3, 32'h80);
            step(2);
        end
        step(4);
        bus.en_i[7] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.gpio_pad_i[7] = (j % 2 == 0);
            step(2);
        end
        step(8);
        check("filter_suppress", bus.gpio_in_o, 32'h0);

        // thresh=0 behaves as thresh=1
        bus.thresh_i      = 8'd0;
        bus.gpio_pad_i[1] = 1'b1;
        push(cyc + 3, 32'h2);
        step(1);
        bus.gpio_pad_i[1] = 1'b0;
        push(cyc + 3, 32'h2);
        step(8);

        // Async reset mid-count on pin 2 (div=5 thresh=4), pin 3 bypassed
        p = cyc;
        bus.div_i         = 16'd5;
        bus.thresh_i      = 8'd4;
        bus.en_i[3]       = 1'b0;
        bus.gpio_pad_i[2] = 1'b1;
        bus.gpio_pad_i[3] = 1'b1;
        push(p + 3, 32'h8);
        step(13);
        check("pre_reset_cnt", 32'(dut.cnt[2]), 32'd2);
        check("pre_reset_out", bus.gpio_in_o, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", bus.gpio_in_o, 32'h0);
        check("async_rst_chg", bus.chg_o, 32'h0);
        check("async_rst_cnt", 32'(dut.cnt[2]), 32'd0);
        exp_lvl = '0;
        step(2);
        rst_n = 1'b1;
        r = cyc;
        push(r + 3, 32'h8);
        push(r + 24, 32'h4);
        step(30);
        check("final_out", bus.gpio_in_o, 32'hC);

        step(5);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Per-pin input conditioner between the GPIO pads and the GPIO controller's pad-input port.
- Synchronises raw pad inputs to the peripheral clock.
- Rejects glitches: an input level must stay stable for a programmable number of prescaled sample ticks before it is passed on.
- Gives the controller's edge detector and interrupt logic clean, bounce-free levels, plus a per-pin "changed" pulse.

Parameters:
- PIN_NUM, 32, number of GPIO pins; matches the controller pin count.
- CNT_WIDTH, 8, width of each per-pin stability counter and of thresh_i.
- DIV_WIDTH, 16, width of the shared sample prescaler and of div_i.

Ports:
- clk_i  input  1  peripheral clock (same as the controller's APB clock).
- rst_n_i  input  1  asynchronous active-low reset.
- gpio_pad_i  input  PIN_NUM  raw asynchronous pad levels.
- en_i  input  PIN_NUM  per-pin filter enable; 0 = bypass (synchroniser only).
- div_i  input  DIV_WIDTH  prescaler terminal value; a tick occurs every div_i+1 cycles.
- thresh_i  input  CNT_WIDTH  consecutive mismatching ticks required to accept a new level; 0 is treated as 1.
- gpio_in_o  output  PIN_NUM  filtered level; feeds the controller's gpio_in_i.
- chg_o  output  PIN_NUM  one-cycle pulse in the first cycle gpio_in_o shows a new value.

Behaviour:
- Single clock; reset is asynchronous and active-low. All flops clear to 0 on rst_n_i=0: synchroniser stages, prescaler, counters, gpio_in_o=0, chg_o=0.
- Synchroniser: two flop stages per pin, giving sync_q. No other logic touches the raw pad input.
- Prescaler: psc_cnt counts up each cycle.
  - When psc_cnt >= div_i: tick=1 and psc_cnt wraps to 0 on the next edge.
  - div_i=0 gives a tick every cycle.
  - Lowering div_i below the current count causes a tick and wrap on the next edge, with no long wrap-around.
- Per-pin filter when en_i[i]=1, evaluated only on a tick (no change between ticks):
  - sync_q[i]==out_q[i]: cnt[i] <= 0.
  - Mismatch and cnt[i]+1 >= max(thresh_i,1): out_q[i] <= sync_q[i], cnt[i] <= 0.
  - Mismatch otherwise: cnt[i] <= cnt[i]+1.
  - The compare is done in CNT_WIDTH+1 bits; cnt never exceeds thresh_i-1, so it never wraps.
- Bypass when en_i[i]=0: out_q[i] <= sync_q[i] every cycle, cnt[i] <= 0.
  - Bypass pad-to-output latency is 3 edges.
  - Switching en 0->1 starts filtering from the current out_q with cnt=0.
  - Switching en 1->0 mid-count discards the count; the output follows sync_q next edge.
- Filtered latency with div=0, thresh=N: new level appears on gpio_in_o at edge 2+N after the pad change.
- A pulse shorter than N consecutive ticks never reaches gpio_in_o.
- A level that returns to out_q before reaching the threshold resets cnt, so bounce restarts the count.
- thresh_i changes take effect at the next tick. If cnt is already >= the new thresh-1, the pending mismatch is accepted at that tick.
- chg_o[i] is registered: chg_q <= out_d ^ out_q. It is high exactly in the first cycle out_q holds the new value, including in bypass mode.
- gpio_in_o = out_q, a direct register output with no combinational path from any input.
- Reset asserted mid-count: everything clears immediately. After release, pins read 0 until the synchroniser and filter accept the pad level. A pad held high therefore produces one chg_o pulse after reset.

Test Plan:
- Reset release with pads=0, en=all-1, div=0, thresh=4 -> gpio_in_o=0 and chg_o=0 for 20 cycles; drive pad[3]=1 at edge k -> gpio_in_o[3]=1 at edge k+6, chg_o[3]=1 for exactly that one cycle.
- Glitch rejection: div=0, thresh=4, pad[0] high for 3 cycles then low -> gpio_in_o[0] stays 0 and cnt returns to 0; a pulse of 4 cycles -> accepted, chg_o[0] pulses once.
- Prescaler: div=9, thresh=3, pad[5] steady-high step -> gpio_in_o[5] rises 21–30 cycles after the synchronised change (3 ticks at 10-cycle spacing); lowering div from 9 to 2 mid-count -> tick on the next edge, no stall.
- Bypass: en[7]=0, pad[7] toggling every 2 cycles -> gpio_in_o[7] follows with 3-edge latency and chg_o[7] pulses on every change; set en[7]=1 with thresh=4 -> toggling is suppressed.
- thresh=0 equals thresh=1: div=0, single 1-cycle-wide synchronised high -> accepted, output rises at edge k+3.
- Async reset mid-count (cnt=2 of 4, div=5) -> all outputs are 0 within the reset cycle; after release, a steady-high pad is re-accepted after the full 2+4-tick latency with one chg_o pulse.
